// File: rtl/jtag_master.sv
// rtl/jtag_master.sv - JTAG initiator: TAP reset, IR/DR shift and idle clocks from a command port
module jtag_master #(
    parameter int MAX_LEN = 32,
    parameter int DIV     = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [5:0]         cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               busy,
    output logic               tck,
    output logic               tms,
    output logic               tdi,
    input  logic               tdo
);

    // Counter wide enough for the longest shift and for the 6-TCK reset prefix.
    localparam int CW = ($clog2(MAX_LEN + 1) < 3) ? 3 : $clog2(MAX_LEN + 1);

    localparam logic [1:0] OP_RESET = 2'b00;
    localparam logic [1:0] OP_IR    = 2'b01;
    localparam logic [1:0] OP_DR    = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        SHIFT,
        POST,
        RESP
    } state_t;

    state_t             state;
    logic [1:0]         op_q;
    logic [CW-1:0]      len_q;
    logic [MAX_LEN-1:0] data_q;
    logic [MAX_LEN-1:0] cap_q;
    logic [MAX_LEN-1:0] mask_q;
    logic [CW-1:0]      cnt;
    logic [7:0]         div_cnt;
    logic [CW-1:0]      eff_len;
    logic               is_shift;
    logic               last_tck;

    // Index of the final TCK of the PRE phase; reset and idle ops live entirely in PRE.
    function automatic logic [CW-1:0] pre_last(input logic [1:0] op, input logic [CW-1:0] len);
        case (op)
            OP_RESET: pre_last = CW'(5);
            OP_IR:    pre_last = CW'(3);
            OP_DR:    pre_last = CW'(2);
            default:  pre_last = len - 1'b1;
        endcase
    endfunction

    // TMS value for PRE bit idx: reset 11111 0, IR 1100, DR 100, idle all zeros.
    function automatic logic pre_tms(input logic [1:0] op, input logic [CW-1:0] idx);
        case (op)
            OP_RESET: pre_tms = (idx < CW'(5));
            OP_IR:    pre_tms = (idx < CW'(2));
            OP_DR:    pre_tms = (idx == '0);
            default:  pre_tms = 1'b0;
        endcase
    endfunction

    // Length 0 behaves as 1; anything beyond the data width is clamped.
    always_comb begin
        if (cmd_len == '0) begin
            eff_len = CW'(1);
        end else if (int'(cmd_len) > MAX_LEN) begin
            eff_len = CW'(MAX_LEN);
        end else begin
            eff_len = CW'(cmd_len);
        end
    end

    // Decode whether the TCK now finishing its high phase is the last of the operation.
    always_comb begin
        is_shift = (op_q == OP_IR) || (op_q == OP_DR);
        last_tck = ((state == PRE) && (cnt == pre_last(op_q, len_q)) && !is_shift) ||
                   ((state == POST) && (cnt == CW'(1)));
    end

    // Command FSM and TCK generator: tms/tdi change as tck falls, tdo captured as tck rises.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            busy      <= 1'b0;
            tck       <= 1'b0;
            tms       <= 1'b1;
            tdi       <= 1'b0;
            op_q      <= OP_RESET;
            len_q     <= '0;
            data_q    <= '0;
            cap_q     <= '0;
            mask_q    <= '0;
            cnt       <= '0;
            div_cnt   <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q      <= cmd_op;
                        len_q     <= eff_len;
                        data_q    <= cmd_data;
                        cap_q     <= '0;
                        mask_q    <= '0;
                        cnt       <= '0;
                        div_cnt   <= '0;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        tck       <= 1'b0;
                        tms       <= pre_tms(cmd_op, '0);
                        tdi       <= 1'b0;
                        state     <= PRE;
                    end
                end
                PRE, SHIFT, POST: begin
                    if (div_cnt != 8'(DIV - 1)) begin
                        div_cnt <= div_cnt + 8'd1;
                    end else begin
                        div_cnt <= '0;
                        if (!tck) begin
                            tck <= 1'b1;
                            if (state == SHIFT) begin
                                cap_q <= cap_q | (mask_q & {MAX_LEN{tdo}});
                            end
                        end else begin
                            tck <= 1'b0;
                            if (last_tck) begin
                                tms       <= 1'b0;
                                tdi       <= 1'b0;
                                busy      <= 1'b0;
                                rsp_valid <= 1'b1;
                                rsp_data  <= cap_q;
                                state     <= RESP;
                            end else begin
                                case (state)
                                    PRE: begin
                                        if (cnt == pre_last(op_q, len_q)) begin
                                            cnt    <= '0;
                                            tms    <= (len_q == CW'(1));
                                            tdi    <= data_q[0];
                                            data_q <= data_q >> 1;
                                            mask_q <= {{(MAX_LEN-1){1'b0}}, 1'b1};
                                            state  <= SHIFT;
                                        end else begin
                                            cnt <= cnt + 1'b1;
                                            tms <= pre_tms(op_q, cnt + 1'b1);
                                            tdi <= 1'b0;
                                        end
                                    end
                                    SHIFT: begin
                                        if (cnt == len_q - 1'b1) begin
                                            cnt   <= '0;
                                            tms   <= 1'b1;
                                            tdi   <= 1'b0;
                                            state <= POST;
                                        end else begin
                                            cnt    <= cnt + 1'b1;
                                            tms    <= (cnt + CW'(2) == len_q);
                                            tdi    <= data_q[0];
                                            data_q <= data_q >> 1;
                                            mask_q <= mask_q << 1;
                                        end
                                    end
                                    default: begin
                                        cnt <= CW'(1);
                                        tms <= 1'b0;
                                        tdi <= 1'b0;
                                    end
                                endcase
                            end
                        end
                    end
                end
                RESP: begin
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_master.sv
// tb/tb_jtag_master.sv - directed bench for jtag_master against a behavioural TAP model
module tb_jtag_master;

    localparam int MAX_LEN = 32;
    localparam int DIV     = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic [1:0]         cmd_op = 2'b00;
    logic [5:0]         cmd_len = 6'd0;
    logic [MAX_LEN-1:0] cmd_data = '0;
    logic               rsp_valid;
    logic [MAX_LEN-1:0] rsp_data;
    logic               busy;
    logic               tck;
    logic               tms;
    logic               tdi;
    logic               tdo_r = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    jtag_master #(.MAX_LEN(MAX_LEN), .DIV(DIV)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
        .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo_r)
    );

    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SHF_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SHF_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
    } tap_t;

    tap_t        tap_st = TLR;
    logic [7:0]  dr = 8'h00;
    logic [7:0]  dr_sr = 8'h00;
    logic [3:0]  ir = 4'h0;
    logic [3:0]  ir_sr = 4'h0;
    logic [63:0] tms_log = '0;
    logic [63:0] tdi_log = '0;
    int          tms_n = 0;
    int          tdi_n = 0;
    logic        prep_req = 1'b0;
    logic        prep_load = 1'b0;
    logic [7:0]  prep_val = 8'h00;

    function automatic tap_t tap_next(input tap_t s, input logic m);
        case (s)
            TLR:     return m ? TLR    : RTI;
            RTI:     return m ? SEL_DR : RTI;
            SEL_DR:  return m ? SEL_IR : CAP_DR;
            CAP_DR:  return m ? EX1_DR : SHF_DR;
            SHF_DR:  return m ? EX1_DR : SHF_DR;
            EX1_DR:  return m ? UPD_DR : PAU_DR;
            PAU_DR:  return m ? EX2_DR : PAU_DR;
            EX2_DR:  return m ? UPD_DR : SHF_DR;
            UPD_DR:  return m ? SEL_DR : RTI;
            SEL_IR:  return m ? TLR    : CAP_IR;
            CAP_IR:  return m ? EX1_IR : SHF_IR;
            SHF_IR:  return m ? EX1_IR : SHF_IR;
            EX1_IR:  return m ? UPD_IR : PAU_IR;
            PAU_IR:  return m ? EX2_IR : PAU_IR;
            EX2_IR:  return m ? UPD_IR : SHF_IR;
            default: return m ? SEL_DR : RTI;
        endcase
    endfunction

    // TAP model: 8-bit DR, 4-bit IR capturing 0001; also logs TMS and shifted TDI per rising TCK.
    always @(posedge tck or posedge prep_req) begin
        if (prep_req) begin
            if (prep_load) dr <= prep_val;
            tms_log <= '0;
            tdi_log <= '0;
            tms_n   <= 0;
            tdi_n   <= 0;
        end else begin
            if (tms_n < 64) tms_log[tms_n[5:0]] <= tms;
            tms_n <= tms_n + 1;
            if (tap_st == SHF_DR) begin
                if (tdi_n < 64) tdi_log[tdi_n[5:0]] <= tdi;
                tdi_n <= tdi_n + 1;
            end
            case (tap_st)
                CAP_DR:  dr_sr <= dr;
                SHF_DR:  dr_sr <= {tdi, dr_sr[7:1]};
                UPD_DR:  dr    <= dr_sr;
                CAP_IR:  ir_sr <= 4'b0001;
                SHF_IR:  ir_sr <= {tdi, ir_sr[3:1]};
                UPD_IR:  ir    <= ir_sr;
                default: ;
            endcase
            tap_st <= tap_next(tap_st, tms);
        end
    end

    // TAP drives TDO on the falling TCK edge.
    always @(negedge tck) begin
        if (tap_st == SHF_DR)      tdo_r <= dr_sr[0];
        else if (tap_st == SHF_IR) tdo_r <= ir_sr[0];
        else                       tdo_r <= 1'b0;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic prep(input logic load, input logic [7:0] val);
        prep_load = load;
        prep_val  = val;
        prep_req  = 1'b1;
        #1;
        prep_req  = 1'b0;
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [5:0] len, input logic [31:0] data);
        int t;
        t = 0;
        cmd_op    = op;
        cmd_len   = len;
        cmd_data  = data;
        cmd_valid = 1'b1;
        while (!cmd_ready && t < 1000) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("accept_busy", busy, 1);
    endtask

    task automatic wait_done(output int bcyc, output int rvs, output logic [31:0] rsp,
                             output logic end_tck, output logic end_tms, output logic ready_ok);
        int   t;
        logic prev_rv;
        t = 0; prev_rv = 1'b0;
        bcyc = 1; rvs = 0; rsp = '1; end_tck = 1'b1; end_tms = 1'b1; ready_ok = 1'b0;
        while (t < 5000) begin
            @(negedge clk);
            t++;
            if (busy) bcyc++;
            if (cmd_ready) begin
                ready_ok = prev_rv;
                break;
            end
            if (rsp_valid) begin
                rvs++;
                rsp     = rsp_data;
                end_tck = tck;
                end_tms = tms;
            end
            prev_rv = rsp_valid;
        end
        check("done_in_time", t < 5000, 1);
    endtask

    int          bc, rv, t;
    logic [31:0] rsp;
    logic        et, em, rok;

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_tck", tck, 0);
        check("rst_tms", tms, 1);
        check("rst_tdi", tdi, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        rst = 1'b0;
        @(negedge clk);

        // TAP reset
        prep(1'b0, 8'h00);
        issue(2'b00, 6'd0, 32'h0);
        wait_done(bc, rv, rsp, et, em, rok);
        check("rst_op_tck_count", tms_n, 6);
        check("rst_op_tms_seq", tms_log, 64'h1F);
        check("rst_op_busy_cycles", bc, 24);
        check("rst_op_rsp_pulses", rv, 1);
        check("rst_op_rsp_data", rsp, 0);
        check("rst_op_tap_rti", tap_st, RTI);
        check("rst_op_ready_after_rsp", rok, 1);

        // DR shift, len 8
        prep(1'b1, 8'hA5);
        issue(2'b10, 6'd8, 32'h3C);
        wait_done(bc, rv, rsp, et, em, rok);
        check("dr_tck_count", tms_n, 13);
        check("dr_tms_seq", tms_log, 64'hC01);
        check("dr_tdi_count", tdi_n, 8);
        check("dr_tdi_seq", tdi_log, 64'h3C);
        check("dr_rsp_data", rsp, 32'hA5);
        check("dr_model_dr", dr, 8'h3C);
        check("dr_busy_cycles", bc, 52);
        check("dr_end_tck", et, 0);
        check("dr_end_tms", em, 0);
        check("dr_tap_rti", tap_st, RTI);

        // IR shift, len 4
        prep(1'b0, 8'h00);
        issue(2'b01, 6'd4, 32'hE);
        wait_done(bc, rv, rsp, et, em, rok);
        check("ir_tck_count", tms_n, 10);
        check("ir_tms_seq", tms_log, 64'h183);
        check("ir_model_ir", ir, 4'hE);
        check("ir_rsp_data", rsp, 32'h1);
        check("ir_busy_cycles", bc, 40);
        check("ir_tap_rti", tap_st, RTI);

        // Idle len 3 with a DR len-0 command held valid throughout
        prep(1'b1, 8'hA5);
        issue(2'b11, 6'd3, 32'hFFFF_FFFF);
        cmd_op = 2'b10; cmd_len = 6'd0; cmd_data = 32'h1; cmd_valid = 1'b1;
        wait_done(bc, rv, rsp, et, em, rok);
        check("idle_tck_count", tms_n, 3);
        check("idle_tms_seq", tms_log, 64'h0);
        check("idle_busy_cycles", bc, 12);
        check("idle_rsp_data", rsp, 0);
        check("b2b_ready_after_rsp", rok, 1);
        prep(1'b0, 8'h00);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("b2b_accepted", busy, 1);
        wait_done(bc, rv, rsp, et, em, rok);
        check("len0_tck_count", tms_n, 6);
        check("len0_tms_seq", tms_log, 64'h19);
        check("len0_rsp_data", rsp, 32'h1);
        check("len0_model_dr", dr, 8'hD2);

        // Length clamp: 40 -> 32
        prep(1'b1, 8'h5A);
        issue(2'b10, 6'd40, 32'h1234_5678);
        wait_done(bc, rv, rsp, et, em, rok);
        check("clamp_tck_count", tms_n, 37);
        check("clamp_busy_cycles", bc, 148);
        check("clamp_rsp_data", rsp, 32'h3456_785A);
        check("clamp_model_dr", dr, 8'h12);

        // Reset during shift bit 3 of an 8-bit DR shift
        prep(1'b0, 8'h00);
        issue(2'b10, 6'd8, 32'hFF);
        t = 0;
        while (tms_n < 7 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("mid_reached_bit3", tms_n, 7);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_tck", tck, 0);
        check("mid_tms", tms, 1);
        check("mid_busy", busy, 0);
        check("mid_rsp_valid", rsp_valid, 0);
        check("mid_cmd_ready", cmd_ready, 1);
        check("mid_rsp_data", rsp_data, 0);
        rst = 1'b0;
        rv = 0;
        repeat (20) begin
            @(negedge clk);
            if (rsp_valid) rv++;
        end
        check("mid_no_rsp", rv, 0);
        prep(1'b0, 8'h00);
        issue(2'b00, 6'd0, 32'h0);
        wait_done(bc, rv, rsp, et, em, rok);
        check("mid_recover_tms_seq", tms_log, 64'h1F);
        check("mid_recover_tap_rti", tap_st, RTI);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
